serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_subtractor                                             |
// | Purpose  : Bit-serial unsigned subtractor. Captures a and b on start,    |
// |            processes one bit per cycle (LSB first) through a single      |
// |            full-subtractor cell and presents a-b with the final borrow.  |
// | Ports    : clk    - rising-edge clock                                    |
// |            rst    - synchronous active-high reset                        |
// |            start  - capture request, honoured only when idle             |
// |            a, b   - minuend / subtrahend (WIDTH bits, unsigned)          |
// |            busy   - high while running or presenting the result         |
// |            done   - one-cycle pulse, result valid                        |
// |            diff   - a-b modulo 2^WIDTH, held until the next result       |
// |            borrow - final borrow out (a < b unsigned)                    |
// |            ovf    - signed overflow (only with SERIAL_SUB_OVF_EN)        |
// | Config   : define SERIAL_SUB_OVF_EN to add the ovf port and its logic.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bflop_q, bflop_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic w_a0;
   logic w_b0;
   logic w_dbit;
   logic w_bout;

   // Full-subtractor cell on the current operand LSBs.
   assign w_a0   = a_q[0];
   assign w_b0   = b_q[0];
   assign w_dbit = w_a0 ^ w_b0 ^ bflop_q;
   assign w_bout = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & bflop_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         bflop_q  <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         bflop_q  <= bflop_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      bflop_d  = bflop_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               b_d     = b;
               res_d   = '0;
               bflop_d = 1'b0;
               cnt_d   = '0;
            end
         end

         S_RUN: begin
            res_d   = {w_dbit, res_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            bflop_d = w_bout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d  = S_DONE;
               // The final bit is still in flight, so take it straight from
               // the cell rather than from the shift register.
               diff_d   = {w_dbit, res_q[WIDTH-1:1]};
               borrow_d = w_bout;
`ifdef SERIAL_SUB_OVF_EN
               // On the last bit the operand LSBs are the captured MSBs and
               // w_dbit is the result MSB.
               ovf_d    = (w_a0 != w_b0) && (w_dbit != w_a0);
`endif
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
   assign done   = (state_q == S_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule
`default_nettype wire
